// File: rtl/stage4_mem_wb_pkg.sv
// Shared types for the MEM/WB stage: FSM states, operation classes and the
// register-address width used on the write-back port.
package stage_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WB     = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ALU   = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_CALL  = 3'd3,
    OP_RET   = 3'd4
  } op_e;

  // CALL wins over RET, and a store wins over a load.
  function automatic op_e classify_op(input logic call_i, input logic ret_i,
                                      input logic wr_i, input logic rd_i);
    op_e op;
    if (call_i) begin
      op = OP_CALL;
    end else if (ret_i) begin
      op = OP_RET;
    end else if (wr_i) begin
      op = OP_STORE;
    end else if (rd_i) begin
      op = OP_LOAD;
    end else begin
      op = OP_ALU;
    end
    return op;
  endfunction

endpackage

// File: rtl/stage4_mem_wb_stack_ptr_unit.sv
// Stack pointer owner: moves SP on completed push/pop and latches a sticky
// fault when a CALL meets a full stack or a RET meets an empty one.
module stack_ptr_unit
  import stage_pkg::*;
#(
  parameter int                ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] SP_INIT = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              call_chk_i,
  input  logic              ret_chk_i,
  output logic [ADDR_W-1:0] sp_o,
  output logic              at_floor_o,
  output logic              at_top_o,
  output logic              fault_o
);

  localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] sp_q, sp_d;
  logic              fault_q, fault_d;

  assign at_floor_o = (sp_q == '0);
  assign at_top_o   = (sp_q == SP_INIT);
  assign sp_o       = sp_q;
  assign fault_o    = fault_q;

  // Next SP and sticky fault
  always_comb begin
    sp_d    = sp_q;
    fault_d = fault_q | (call_chk_i & at_floor_o) | (ret_chk_i & at_top_o);
    if (push_i) begin
      sp_d = sp_q - SP_ONE;
    end else if (pop_i) begin
      sp_d = sp_q + SP_ONE;
    end else begin
      sp_d = sp_q;
    end
  end

  // SP and fault registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= SP_INIT;
      fault_q <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      fault_q <= fault_d;
    end
  end

endmodule

// File: rtl/stage4_mem_wb.sv
// Combined memory-access / write-back stage: loads, stores and CALL/RET stack
// traffic over a req/ack memory port, then one write-back pulse into stage2.
module stage4_mem_wb
  import stage_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter int                ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] SP_INIT = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              En_Pipeline,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] Store_data_in,
  input  logic [DATA_W-1:0] Return_Addr_in,
  input  logic [REG_AW-1:0] Addr_Write_Reg_in,
  input  logic              Reg_Write_En_in,
  input  logic              WB_Mux_sel_in,
  input  logic              Memory_Read_in,
  input  logic              Memory_Write_in,
  input  logic              CALL_flag_in,
  input  logic              RET_flag_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [REG_AW-1:0] Addr_Write_Reg_out,
  output logic              Reg_Write_En_out,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] Forward_Data_out,
  output logic [ADDR_W-1:0] SP_Data,
  output logic              RET_valid,
  output logic [DATA_W-1:0] RET_Addr,
  output logic              Stall_out,
  output logic              Stack_fault
);

  localparam logic [ADDR_W-1:0] SP_ONE = ADDR_W'(1);

  state_e            state_q, state_d;
  op_e               op_in_s, op_q;
  logic [DATA_W-1:0] alu_q, wdata_q, rdata_q, wb_data_s;
  logic [ADDR_W-1:0] addr_q, addr_s;
  logic [REG_AW-1:0] dest_q;
  logic              rwe_q, wbsel_q, we_q, ret_ok_q;
  logic              capture_s, fault_hit_s, ack_s, at_floor_s, at_top_s;

  assign op_in_s     = classify_op(CALL_flag_in, RET_flag_in, Memory_Write_in, Memory_Read_in);
  assign capture_s   = En_Pipeline && (state_q == S_IDLE);
  assign fault_hit_s = ((op_in_s == OP_CALL) && at_floor_s) || ((op_in_s == OP_RET) && at_top_s);
  assign ack_s       = (state_q == S_ACCESS) && mem_ack;
  assign wb_data_s   = wbsel_q ? rdata_q : alu_q;

  stack_ptr_unit #(.ADDR_W(ADDR_W), .SP_INIT(SP_INIT)) u_sp (
    .clk        (clk),
    .reset      (reset),
    .push_i     (ack_s && (op_q == OP_CALL)),
    .pop_i      (ack_s && (op_q == OP_RET)),
    .call_chk_i (capture_s && (op_in_s == OP_CALL)),
    .ret_chk_i  (capture_s && (op_in_s == OP_RET)),
    .sp_o       (SP_Data),
    .at_floor_o (at_floor_s),
    .at_top_o   (at_top_s),
    .fault_o    (Stack_fault)
  );

  // Push writes at SP, pop reads the slot above it
  always_comb begin
    addr_s = ALU_result_in[ADDR_W-1:0];
    case (op_in_s)
      OP_CALL: addr_s = SP_Data;
      OP_RET:  addr_s = SP_Data + SP_ONE;
      default: addr_s = ALU_result_in[ADDR_W-1:0];
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; faulted stack ops skip the memory access
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!En_Pipeline) begin
          state_d = S_IDLE;
        end else if ((op_in_s == OP_ALU) || fault_hit_s) begin
          state_d = S_WB;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          state_d = S_WB;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Op capture and read-data latch
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= OP_ALU;
      alu_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      addr_q   <= '0;
      dest_q   <= '0;
      rwe_q    <= 1'b0;
      wbsel_q  <= 1'b0;
      we_q     <= 1'b0;
      ret_ok_q <= 1'b0;
    end else if (capture_s) begin
      op_q     <= op_in_s;
      alu_q    <= ALU_result_in;
      wdata_q  <= (op_in_s == OP_CALL) ? Return_Addr_in : Store_data_in;
      rdata_q  <= '0;
      addr_q   <= addr_s;
      dest_q   <= Addr_Write_Reg_in;
      rwe_q    <= Reg_Write_En_in && ((op_in_s == OP_ALU) || (op_in_s == OP_LOAD));
      wbsel_q  <= WB_Mux_sel_in;
      we_q     <= (op_in_s == OP_STORE) || (op_in_s == OP_CALL);
      ret_ok_q <= (op_in_s == OP_RET) && !fault_hit_s;
    end else if (ack_s) begin
      rdata_q  <= mem_rdata;
    end
  end

  // Outputs decoded from the state and latched op
  always_comb begin
    mem_req            = 1'b0;
    mem_we             = 1'b0;
    mem_addr           = '0;
    mem_wdata          = '0;
    Stall_out          = 1'b0;
    Reg_Write_En_out   = 1'b0;
    Addr_Write_Reg_out = '0;
    data_out           = '0;
    Forward_Data_out   = '0;
    RET_valid          = 1'b0;
    RET_Addr           = '0;
    case (state_q)
      S_ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        Stall_out = 1'b1;
      end
      S_WB: begin
        Reg_Write_En_out   = rwe_q;
        Addr_Write_Reg_out = dest_q;
        data_out           = wb_data_s;
        Forward_Data_out   = wb_data_s;
        RET_valid          = ret_ok_q;
        RET_Addr           = ret_ok_q ? rdata_q : '0;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_stage4_mem_wb.sv
// Self-checking bench for stage4_mem_wb: directed vector table, stack corner
// sequences and randomized ops checked against a transaction-level model.
module tb_stage4_mem_wb;

  logic        clk = 1'b0;
  logic        reset, En_Pipeline;
  logic [31:0] ALU_result_in, Store_data_in, Return_Addr_in, mem_rdata;
  logic [4:0]  Addr_Write_Reg_in;
  logic        Reg_Write_En_in, WB_Mux_sel_in, Memory_Read_in, Memory_Write_in;
  logic        CALL_flag_in, RET_flag_in, mem_ack;
  logic        mem_req, mem_we, Reg_Write_En_out, RET_valid, Stall_out, Stack_fault;
  logic [7:0]  mem_addr, SP_Data;
  logic [31:0] mem_wdata, data_out, Forward_Data_out, RET_Addr;
  logic [4:0]  Addr_Write_Reg_out;

  always #5 clk = ~clk;

  stage4_mem_wb dut (
    .clk(clk), .reset(reset), .En_Pipeline(En_Pipeline),
    .ALU_result_in(ALU_result_in), .Store_data_in(Store_data_in),
    .Return_Addr_in(Return_Addr_in), .Addr_Write_Reg_in(Addr_Write_Reg_in),
    .Reg_Write_En_in(Reg_Write_En_in), .WB_Mux_sel_in(WB_Mux_sel_in),
    .Memory_Read_in(Memory_Read_in), .Memory_Write_in(Memory_Write_in),
    .CALL_flag_in(CALL_flag_in), .RET_flag_in(RET_flag_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .Addr_Write_Reg_out(Addr_Write_Reg_out), .Reg_Write_En_out(Reg_Write_En_out),
    .data_out(data_out), .Forward_Data_out(Forward_Data_out), .SP_Data(SP_Data),
    .RET_valid(RET_valid), .RET_Addr(RET_Addr), .Stall_out(Stall_out),
    .Stack_fault(Stack_fault)
  );

  typedef struct {
    logic call, ret, wr, rd, wbsel, rwe;
    logic [4:0] dest;
    logic [31:0] alu, sd, ra;
    int wait_n;
    logic acc, we;
    logic [7:0] addr;
    logic [31:0] wdata;
    logic x_rwe;
    logic [31:0] x_data;
    logic x_retv;
    logic [31:0] x_reta;
    logic [7:0] x_sp;
    logic x_fault;
  } vec_t;

  int n_checks = 0;
  int n_err = 0;
  logic [31:0] bus_mem [256];
  logic [31:0] ref_mem [256];
  logic [7:0]  m_sp;
  logic        m_fault;
  vec_t        tbl [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic call, ret, wr, rd, wbsel, rwe,
                              input logic [4:0] dest, input logic [31:0] alu, sd, ra,
                              input int wait_n, input logic acc, we,
                              input logic [7:0] addr, input logic [31:0] wdata,
                              input logic x_rwe, input logic [31:0] x_data,
                              input logic x_retv, input logic [31:0] x_reta,
                              input logic [7:0] x_sp, input logic x_fault);
    vec_t v;
    v.call = call; v.ret = ret; v.wr = wr; v.rd = rd; v.wbsel = wbsel; v.rwe = rwe;
    v.dest = dest; v.alu = alu; v.sd = sd; v.ra = ra; v.wait_n = wait_n;
    v.acc = acc; v.we = we; v.addr = addr; v.wdata = wdata;
    v.x_rwe = x_rwe; v.x_data = x_data; v.x_retv = x_retv; v.x_reta = x_reta;
    v.x_sp = x_sp; v.x_fault = x_fault;
    return v;
  endfunction

  // Transaction-level reference: what one op should do to memory, SP and write-back.
  task automatic predict(input vec_t vi, output vec_t vo);
    logic [7:0] up;
    vo = vi;
    vo.acc = 1'b0; vo.we = 1'b0; vo.addr = 8'h00; vo.wdata = 32'h0;
    vo.x_rwe = 1'b0; vo.x_data = 32'h0; vo.x_retv = 1'b0; vo.x_reta = 32'h0;
    up = m_sp + 8'd1;
    if (vi.call) begin
      if (m_sp == 8'h00) m_fault = 1'b1;
      else begin
        vo.acc = 1'b1; vo.we = 1'b1; vo.addr = m_sp; vo.wdata = vi.ra;
        ref_mem[m_sp] = vi.ra;
        m_sp = m_sp - 8'd1;
      end
    end else if (vi.ret) begin
      if (m_sp == 8'hFF) m_fault = 1'b1;
      else begin
        vo.acc = 1'b1; vo.addr = up; vo.x_retv = 1'b1; vo.x_reta = ref_mem[up];
        m_sp = up;
      end
    end else if (vi.wr) begin
      vo.acc = 1'b1; vo.we = 1'b1; vo.addr = vi.alu[7:0]; vo.wdata = vi.sd;
      ref_mem[vi.alu[7:0]] = vi.sd;
    end else if (vi.rd) begin
      vo.acc = 1'b1; vo.addr = vi.alu[7:0]; vo.x_rwe = vi.rwe;
      vo.x_data = vi.wbsel ? ref_mem[vi.alu[7:0]] : vi.alu;
    end else begin
      vo.x_rwe = vi.rwe; vo.x_data = vi.alu;
    end
    vo.x_sp = m_sp;
    vo.x_fault = m_fault;
  endtask

  task automatic clear_inputs();
    En_Pipeline = 1'b0; CALL_flag_in = 1'b0; RET_flag_in = 1'b0;
    Memory_Read_in = 1'b0; Memory_Write_in = 1'b0; WB_Mux_sel_in = 1'b0;
    Reg_Write_En_in = 1'b0; Addr_Write_Reg_in = 5'd0; ALU_result_in = 32'h0;
    Store_data_in = 32'h0; Return_Addr_in = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; clear_inputs(); mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_sp = 8'hFF; m_fault = 1'b0;
  endtask

  // Issue one op from IDLE (called at a negedge), act as memory, check every cycle.
  task automatic run_op(input vec_t v);
    int wb_k;
    logic in_acc;
    CALL_flag_in = v.call; RET_flag_in = v.ret; Memory_Write_in = v.wr;
    Memory_Read_in = v.rd; WB_Mux_sel_in = v.wbsel; Reg_Write_En_in = v.rwe;
    Addr_Write_Reg_in = v.dest; ALU_result_in = v.alu; Store_data_in = v.sd;
    Return_Addr_in = v.ra; En_Pipeline = 1'b1;
    @(posedge clk);
    #1 clear_inputs();
    wb_k = v.acc ? v.wait_n + 2 : 1;
    for (int k = 1; k <= wb_k + 1; k++) begin
      @(negedge clk);
      in_acc = v.acc && (k <= v.wait_n + 1);
      chk("mem_req", mem_req, in_acc);
      chk("stall", Stall_out, in_acc);
      if (in_acc) begin
        chk("mem_addr", mem_addr, v.addr);
        chk("mem_we", mem_we, v.we);
        if (v.we) chk("mem_wdata", mem_wdata, v.wdata);
      end
      chk("reg_we", Reg_Write_En_out, (k == wb_k) && v.x_rwe);
      chk("ret_valid", RET_valid, (k == wb_k) && v.x_retv);
      if ((k == wb_k) && v.x_rwe) begin
        chk("wb_dest", Addr_Write_Reg_out, v.dest);
        chk("wb_data", data_out, v.x_data);
        chk("fwd_data", Forward_Data_out, v.x_data);
      end
      if ((k == wb_k) && v.x_retv) chk("ret_addr", RET_Addr, v.x_reta);
      if (k == wb_k + 1) begin
        chk("sp", SP_Data, v.x_sp);
        chk("fault", Stack_fault, v.x_fault);
      end
      if (in_acc && (k == v.wait_n + 1)) begin
        mem_ack = 1'b1;
        mem_rdata = bus_mem[mem_addr];
        if (mem_we) bus_mem[mem_addr] = mem_wdata;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
      end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v, e;
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; clear_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; m_sp = 8'hFF; m_fault = 1'b0;

    chk("rst_req", mem_req, 1'b0);
    chk("rst_stall", Stall_out, 1'b0);
    chk("rst_we", Reg_Write_En_out, 1'b0);
    chk("rst_data", data_out, 32'h0);
    chk("rst_retv", RET_valid, 1'b0);
    chk("rst_sp", SP_Data, 8'hFF);
    chk("rst_fault", Stack_fault, 1'b0);

    //          call ret wr rd wbs rwe dst alu           sd            ra       w   acc we addr  wdata         xrwe xdata         rv xreta    sp     flt
    tbl[0]  = mk(0, 0, 0, 0, 0, 1, 5, 32'd25,       32'h0,        32'h0,  0,  0, 0, 8'h00, 32'h0,        1, 32'd25,       0, 32'h0,  8'hFF, 0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 1, 7, 32'h10,       32'hDEADBEEF, 32'h0,  3,  1, 1, 8'h10, 32'hDEADBEEF, 0, 32'h0,        0, 32'h0,  8'hFF, 0);
    tbl[2]  = mk(0, 0, 0, 1, 1, 1, 3, 32'h10,       32'h0,        32'h0,  3,  1, 0, 8'h10, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0,  8'hFF, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 1, 4, 32'h0,        32'h0,        32'h40, 1,  1, 1, 8'hFF, 32'h40,       0, 32'h0,        0, 32'h0,  8'hFE, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 1, 4, 32'h0,        32'h0,        32'h0,  2,  1, 0, 8'hFF, 32'h0,        0, 32'h0,        1, 32'h40, 8'hFF, 0);
    tbl[5]  = mk(1, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h55, 0,  1, 1, 8'hFF, 32'h55,       0, 32'h0,        0, 32'h0,  8'hFE, 0);
    tbl[6]  = mk(0, 0, 1, 1, 1, 1, 6, 32'h20,       32'h1234,     32'h0,  1,  1, 1, 8'h20, 32'h1234,     0, 32'h0,        0, 32'h0,  8'hFE, 0);
    tbl[7]  = mk(0, 0, 0, 1, 0, 1, 9, 32'h20,       32'h0,        32'h0,  0,  1, 0, 8'h20, 32'h0,        1, 32'h20,       0, 32'h0,  8'hFE, 0);
    tbl[8]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  1,  1, 0, 8'hFF, 32'h0,        0, 32'h0,        1, 32'h55, 8'hFF, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,  0,  0, 0, 8'h00, 32'h0,        0, 32'h0,        0, 32'h0,  8'hFF, 1);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 0, 32'hABCD,     32'h0,        32'h0,  0,  0, 0, 8'h00, 32'h0,        1, 32'hABCD,     0, 32'h0,  8'hFF, 1);
    for (int i = 0; i < 11; i++) begin
      predict(tbl[i], e);
      run_op(tbl[i]);
    end

    // Reset while a RET is outstanding, then a late ack
    do_reset();
    v = mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h77, 1, 0, 0, 8'h00, 32'h0, 0, 32'h0, 0, 32'h0, 8'h00, 0);
    predict(v, e);
    run_op(e);
    RET_flag_in = 1'b1; En_Pipeline = 1'b1;
    @(posedge clk);
    #1 clear_inputs();
    @(negedge clk);
    chk("abort_req_before", mem_req, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_req_after", mem_req, 1'b0);
    chk("abort_stall", Stall_out, 1'b0);
    chk("abort_sp", SP_Data, 8'hFF);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h77;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 32'h0;
      chk("late_ack_retv", RET_valid, 1'b0);
      chk("late_ack_we", Reg_Write_En_out, 1'b0);
      chk("late_ack_sp", SP_Data, 8'hFF);
    end
    m_sp = 8'hFF; m_fault = 1'b0;

    // RET on an empty stack, then fill the stack to the floor and overflow it
    do_reset();
    v = mk(0, 1, 0, 0, 0, 1, 2, 32'h0, 32'h0, 32'h0, 0, 0, 0, 8'h00, 32'h0, 0, 32'h0, 0, 32'h0, 8'h00, 0);
    predict(v, e);
    run_op(e);
    for (int i = 0; i < 256; i++) begin
      v = mk(1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h1000 + i, 0, 0, 0, 8'h00, 32'h0, 0, 32'h0, 0, 32'h0, 8'h00, 0);
      predict(v, e);
      run_op(e);
    end
    chk("floor_sp", SP_Data, 8'h00);
    chk("floor_fault", Stack_fault, 1'b1);

    // Randomized mix against the reference model
    do_reset();
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 9);
      v = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 8'h00, 32'h0, 0, 32'h0, 0, 32'h0, 8'h00, 0);
      v.call = (r == 0) || (r == 1);
      v.ret = (r == 1) || (r == 2);
      v.wr = (r == 3) || (r == 4);
      v.rd = (r == 4) || (r == 5) || (r == 6);
      v.wbsel = ((r == 5) || (r == 6)) ? 1'($urandom_range(0, 1)) : 1'b0;
      v.rwe = 1'($urandom_range(0, 1));
      v.dest = 5'($urandom_range(0, 31));
      v.alu = $urandom; v.sd = $urandom; v.ra = $urandom;
      v.wait_n = $urandom_range(0, 3);
      predict(v, e);
      run_op(e);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
